// File: rtl/superfx_seq_multiplier.sv
// GSU multi-cycle radix-2^BPC shift-add multiplier with start/done handshake (MULT/FMULT).
// Optional build macro MULT_EARLY_OUT_EN: finish as soon as the remaining multiplier bits are zero.
module superfx_seq_multiplier #(
   parameter int WIDTH = 16,
   parameter int BPC   = 2
) (
   input  logic               clk_21mhz,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   input  logic               frac,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [WIDTH-1:0]   z,
   output logic               cy,
   output logic               sgn,
   output logic               zero
);

   localparam int N  = WIDTH / BPC;
   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t          r_state;
   state_t          w_next;

   logic [PW-1:0]    r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [PW-1:0]    r_acc;
   logic [CW-1:0]    r_cnt;
   logic             r_neg;
   logic             r_frac;
   logic             r_done;
   logic [PW-1:0]    r_product;
   logic [WIDTH-1:0] r_z;
   logic             r_cy;
   logic             r_sgn;
   logic             r_zero;

   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH-1:0] w_mplier_rest;
   logic [PW-1:0]    w_pp;
   logic [PW-1:0]    w_fixed;
   logic [WIDTH-1:0] w_z;
   logic             w_last;

   // Magnitudes fit exactly in WIDTH unsigned bits, including -2^(WIDTH-1).
   assign w_a_mag       = (is_signed && a[WIDTH-1]) ? -a : a;
   assign w_b_mag       = (is_signed && b[WIDTH-1]) ? -b : b;
   assign w_mplier_rest = r_mplier >> BPC;

`ifdef MULT_EARLY_OUT_EN
   assign w_last = (w_mplier_rest == '0) || (r_cnt == CW'(N - 1));
`else
   assign w_last = (r_cnt == CW'(N - 1));
`endif

   // Partial product for the BPC multiplier bits retired this cycle.
   always_comb begin
      // NOTE: default first so no path through the loop leaves w_pp unassigned (no latch).
      w_pp = '0;
      for (int j = 0; j < BPC; j++) begin
         if (r_mplier[j]) w_pp = w_pp + (r_mcand << j);
      end
   end

   assign w_fixed = r_neg ? -r_acc : r_acc;
   assign w_z     = r_frac ? w_fixed[PW-1:WIDTH] : w_fixed[WIDTH-1:0];

   always_ff @(posedge clk_21mhz or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_FIX;
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != S_IDLE);
   end

   always_ff @(posedge clk_21mhz or negedge reset) begin
      if (!reset) begin
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_neg     <= 1'b0;
         r_frac    <= 1'b0;
         r_done    <= 1'b0;
         r_product <= '0;
         r_z       <= '0;
         r_cy      <= 1'b0;
         r_sgn     <= 1'b0;
         r_zero    <= 1'b1;
      end else begin
         r_done <= (r_state == S_FIX);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                  r_mplier <= w_b_mag;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_frac   <= frac;
               end
            end
            S_RUN: begin
               r_acc    <= r_acc + w_pp;
               r_mcand  <= r_mcand << BPC;
               r_mplier <= w_mplier_rest;
               r_cnt    <= r_cnt + 1'b1;
            end
            S_FIX: begin
               r_product <= w_fixed;
               r_z       <= w_z;
               r_cy      <= r_frac & w_fixed[WIDTH-1];
               r_sgn     <= w_z[WIDTH-1];
               r_zero    <= (w_z == '0);
            end
            default: ;
         endcase
      end
   end

   assign done    = r_done;
   assign product = r_product;
   assign z       = r_z;
   assign cy      = r_cy;
   assign sgn     = r_sgn;
   assign zero    = r_zero;

endmodule

// File: tb/tb_superfx_seq_multiplier.sv
// Scoreboard bench for superfx_seq_multiplier (WIDTH=16, BPC=2): directed vectors with hand-computed products.
// Honours MULT_EARLY_OUT_EN when predicting start-to-done latency.
module tb_superfx_seq_multiplier;

   localparam int W = 16;

   logic           clk_21mhz = 1'b0;
   logic           reset     = 1'b0;
   logic           start     = 1'b0;
   logic [W-1:0]   a         = '0;
   logic [W-1:0]   b         = '0;
   logic           is_signed = 1'b0;
   logic           frac      = 1'b0;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;
   logic [W-1:0]   z;
   logic           cy;
   logic           sgn;
   logic           zero;

   superfx_seq_multiplier #(.WIDTH(W), .BPC(2)) dut (
      .clk_21mhz (clk_21mhz),
      .reset     (reset),
      .start     (start),
      .a         (a),
      .b         (b),
      .is_signed (is_signed),
      .frac      (frac),
      .busy      (busy),
      .done      (done),
      .product   (product),
      .z         (z),
      .cy        (cy),
      .sgn       (sgn),
      .zero      (zero)
   );

   always #5 clk_21mhz = ~clk_21mhz;

   typedef struct {
      logic [2*W-1:0] product;
      logic [W-1:0]   z;
      logic           cy;
      logic           sgn;
      logic           zero;
      int             start_cyc;
      int             lat;
   } exp_t;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic           s;
      logic           f;
      logic [2*W-1:0] p;
   } vec_t;

   exp_t           sb_q[$];
   int             total     = 0;
   int             bad       = 0;
   int             cyc       = 0;
   int             cur_start = 0;
   int             free_cyc  = 0;
   logic [2*W-1:0] last_p    = '0;

   always @(posedge clk_21mhz) cyc = cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int exp_lat(input logic [W-1:0] bv, input logic s);
`ifdef MULT_EARLY_OUT_EN
      logic [W-1:0] mag;
      int           n;
      mag = (s && bv[W-1]) ? -bv : bv;
      n   = 1;
      for (int i = 0; i < W / 2; i++) begin
         if ((mag >> (2 * i)) != '0) n = i + 1;
      end
      return n + 1;
`else
      return W / 2 + 1;
`endif
   endfunction

   function automatic exp_t make_exp(input logic [2*W-1:0] p, input logic f);
      exp_t e;
      e.product   = p;
      e.z         = f ? p[2*W-1:W] : p[W-1:0];
      e.cy        = f ? p[W-1] : 1'b0;
      e.sgn       = e.z[W-1];
      e.zero      = (e.z == '0);
      e.start_cyc = 0;
      e.lat       = 0;
      return e;
   endfunction

   // Monitor: compares every done against the scoreboard and checks busy/hold behaviour.
   always @(negedge clk_21mhz) begin
      if (!reset) begin
         last_p = '0;
      end else begin
         check("busy", 64'(busy), 64'(cyc >= cur_start && cyc < free_cyc));
         if (done) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("product", 64'(product), 64'(e.product));
               check("z",       64'(z),       64'(e.z));
               check("cy",      64'(cy),      64'(e.cy));
               check("sgn",     64'(sgn),     64'(e.sgn));
               check("zero",    64'(zero),    64'(e.zero));
               check("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
               last_p = e.product;
            end
         end else begin
            check("hold", 64'(product), 64'(last_p));
         end
      end
   end

   // Waits for model idle, then drives a one-cycle start and pushes the expected result.
   task automatic issue(input vec_t v);
      int   guard;
      exp_t e;
      guard = 0;
      @(negedge clk_21mhz);
      while (cyc < free_cyc && guard < 100) begin
         @(negedge clk_21mhz);
         guard++;
      end
      if (guard >= 100) check("idle_timeout", 64'(1), 64'(0));
      a         = v.a;
      b         = v.b;
      is_signed = v.s;
      frac      = v.f;
      start     = 1'b1;
      e           = make_exp(v.p, v.f);
      e.start_cyc = cyc + 1;
      e.lat       = exp_lat(v.b, v.s);
      sb_q.push_back(e);
      cur_start = cyc + 1;
      free_cyc  = cyc + 1 + e.lat;
      @(negedge clk_21mhz);
      start     = 1'b0;
      a         = ~v.a;
      b         = ~v.b;
      is_signed = ~v.s;
      frac      = ~v.f;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb_q.size() != 0 && guard < 300) begin
         @(negedge clk_21mhz);
         guard++;
      end
      check("drain_timeout", 64'(sb_q.size()), 64'(0));
   endtask

   vec_t vecs[$];

   initial begin
      vecs = '{
         '{16'h00FF, 16'h00FF, 1'b0, 1'b0, 32'h0000FE01},
         '{16'hFFFF, 16'h0002, 1'b1, 1'b0, 32'hFFFFFFFE},
         '{16'h8000, 16'h8000, 1'b1, 1'b1, 32'h40000000},
         '{16'h0180, 16'h0100, 1'b0, 1'b1, 32'h00018000},
         '{16'h1234, 16'h0001, 1'b0, 1'b0, 32'h00001234},
         '{16'h0000, 16'h5555, 1'b0, 1'b0, 32'h00000000},
         '{16'h8000, 16'h8000, 1'b0, 1'b0, 32'h40000000},
         '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001},
         '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 32'h00000001},
         '{16'h7FFF, 16'h8000, 1'b1, 1'b1, 32'hC0008000},
         '{16'h1234, 16'h0000, 1'b0, 1'b0, 32'h00000000},
         '{16'h0003, 16'hFFFD, 1'b1, 1'b0, 32'hFFFFFFF7}
      };

      // Reset values while reset is held low.
      repeat (2) @(negedge clk_21mhz);
      check("rst_busy",    64'(busy),    64'(0));
      check("rst_done",    64'(done),    64'(0));
      check("rst_product", 64'(product), 64'(0));
      check("rst_z",       64'(z),       64'(0));
      check("rst_zero",    64'(zero),    64'(1));
      check("rst_cy",      64'(cy),      64'(0));
      check("rst_sgn",     64'(sgn),     64'(0));
      #2 reset = 1'b1;

      foreach (vecs[i]) issue(vecs[i]);
      drain();

      // Start held high: accepted only when idle, including in the done cycle.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_21mhz);
         a = 16'h0011; b = 16'h0011; is_signed = 1'b0; frac = 1'b0;
         start = 1'b1;
         if (cyc >= free_cyc) begin
            exp_t e;
            e           = make_exp(32'h00000121, 1'b0);
            e.start_cyc = cyc + 1;
            e.lat       = exp_lat(16'h0011, 1'b0);
            sb_q.push_back(e);
            cur_start = cyc + 1;
            free_cyc  = cyc + 1 + e.lat;
         end
      end
      @(negedge clk_21mhz);
      start = 1'b0;
      drain();

      // Reset in the middle of RUN aborts without a done pulse.
      issue('{16'h1234, 16'h5678, 1'b0, 1'b0, 32'h06260060});
      while (cyc < cur_start + 4) @(negedge clk_21mhz);
      #2;
      reset = 1'b0;
      sb_q.delete();
      free_cyc  = cyc;
      cur_start = cyc;
      @(negedge clk_21mhz);
      check("abort_busy",    64'(busy),    64'(0));
      check("abort_done",    64'(done),    64'(0));
      check("abort_product", 64'(product), 64'(0));
      check("abort_zero",    64'(zero),    64'(1));
      #2 reset = 1'b1;
      repeat (12) @(negedge clk_21mhz);

      issue('{16'h00FF, 16'h00FF, 1'b0, 1'b0, 32'h0000FE01});
      drain();
      repeat (3) @(negedge clk_21mhz);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
